// File: rtl/neo_pkg.sv
// -----------------------------------------------------------------------------
// neo_pkg
// Shared definitions for the NeoPixel pattern subsystem: pixel count, colour
// channel encodings, brightness levels, the port arbiter state type and the
// counter widths used by the arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package neo_pkg;

   localparam int NUM_PIXELS = 5;

   typedef enum logic [1:0] {
      COLOR_R = 2'd0,
      COLOR_G = 2'd1,
      COLOR_B = 2'd2
   } color_index_t;

   localparam logic [7:0] LEVEL_OFF  = 8'h00;
   localparam logic [7:0] LEVEL_LOW  = 8'h05;
   localparam logic [7:0] LEVEL_MID  = 8'h10;
   localparam logic [7:0] LEVEL_HIGH = 8'h20;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN     = 2'd1,
      SEND    = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam int FRAME_CNT_W = 16;
   localparam int HOLD_CNT_W  = 23;

   // Width of a requester index for 2..4 requesters.
   function automatic int idx_width(input int num_req);
      return (num_req > 2) ? 2 : 1;
   endfunction

endpackage

// File: rtl/neo_counter.sv
// -----------------------------------------------------------------------------
// neo_counter
// Generic up-counter with synchronous clear; wraps naturally at 2**WIDTH.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high reset (count -> 0)
//   clear  in   synchronous clear (count -> 0), has priority over inc
//   inc    in   increment enable
//   count  out  current count value
// -----------------------------------------------------------------------------
module neo_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/neo_rr_picker.sv
// -----------------------------------------------------------------------------
// neo_rr_picker
// Combinational round-robin selector: picks the first set request bit strictly
// after last_owner, wrapping around to bit 0.
// Ports:
//   req         in   request vector
//   last_owner  in   index of the most recent owner
//   pick        out  one-hot winner (zero when no request)
//   valid       out  at least one request is pending
// -----------------------------------------------------------------------------
module neo_rr_picker
   import neo_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic [NUM_REQ-1:0] pick,
   output logic               valid
);

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] upper_req;
   logic [NUM_REQ-1:0] src;

   // Bits strictly above last_owner have priority; if none of them request,
   // the search wraps to the full vector starting at bit 0.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
         assign upper_mask[gi] = (IDX_W'(gi) > last_owner);
      end
   endgenerate

   always_comb begin
      upper_req = req & upper_mask;
      src       = (|upper_req) ? upper_req : req;
      // Isolate the lowest set bit.
      pick      = src & (~src + ONE);
      valid     = |req;
   end

endmodule

// File: rtl/neo_port_arbiter.sv
// -----------------------------------------------------------------------------
// neo_port_arbiter
// Shares the single NeoPixel driver load/send port between NUM_REQ pattern
// producers. A grant is frame-atomic: the owner keeps the port from its first
// load until the driver reports done_wait for its send. Owners rotate
// round-robin, with a one-cycle RELEASE bubble between frames.
//
// Optional build macro: NEO_ARB_TIMEOUT_EN
//   Defined   : a hold watchdog revokes a grant that sits in OWN for
//               TIMEOUT_CYCLES cycles without an accepted send (timeout_err
//               pulses for one cycle).
//   Undefined : no watchdog logic; timeout_err is constant 0.
//
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   req[NUM_REQ]              per-requester request, held until done
//   req_load_color/send_it    per-requester strobes
//   req_pixel/color_index,
//   req_color_level           flattened per-requester data (slice i = req i)
//   gnt                       one-hot grant, zero when no owner
//   req_ready_to_load/send    driver ready routed to the owner only
//   req_done                  one-cycle pulse to the owner at frame end
//   ready_to_load/send,
//   done_wait                 status from the driver
//   load_color, send_it,
//   pixel/color_index,
//   color_level               command/data to the driver
//   frames_sent               completed frame count (wraps)
//   timeout_err               one-cycle pulse on watchdog revoke
// -----------------------------------------------------------------------------
module neo_port_arbiter
   import neo_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     req_load_color,
   input  logic [NUM_REQ-1:0]     req_send_it,
   input  logic [3*NUM_REQ-1:0]   req_pixel_index,
   input  logic [2*NUM_REQ-1:0]   req_color_index,
   input  logic [8*NUM_REQ-1:0]   req_color_level,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     req_ready_to_load,
   output logic [NUM_REQ-1:0]     req_ready_to_send,
   output logic [NUM_REQ-1:0]     req_done,
   input  logic                   ready_to_load,
   input  logic                   ready_to_send,
   input  logic                   done_wait,
   output logic                   load_color,
   output logic                   send_it,
   output logic [2:0]             pixel_index,
   output logic [1:0]             color_index,
   output logic [7:0]             color_level,
   output logic [FRAME_CNT_W-1:0] frames_sent,
   output logic                   timeout_err
);

   localparam int IDX_W = idx_width(NUM_REQ);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] last_owner_q, last_owner_d;

   logic [NUM_REQ-1:0] pick;
   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;

   logic               hold_expired;
   logic               timeout_fire;
   logic               frame_done;

   // Per-requester data unpacked so the owner slice can be selected by index.
   logic [2:0] pixel_arr [NUM_REQ];
   logic [1:0] color_arr [NUM_REQ];
   logic [7:0] level_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign pixel_arr[gi] = req_pixel_index[gi*3 +: 3];
         assign color_arr[gi] = req_color_index[gi*2 +: 2];
         assign level_arr[gi] = req_color_level[gi*8 +: 8];
      end
   endgenerate

   neo_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req        (req),
      .last_owner (last_owner_q),
      .pick       (pick),
      .valid      (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

   // The grant is a pure function of state and owner, so it drops in the
   // same edge that enters RELEASE or IDLE.
   always_comb begin
      gnt = '0;
      if ((state_q == OWN) || (state_q == SEND)) begin
         gnt[owner_q] = 1'b1;
      end
   end

   assign req_ready_to_load = gnt & {NUM_REQ{ready_to_load}};
   assign req_ready_to_send = gnt & {NUM_REQ{ready_to_send}};

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      load_color   = 1'b0;
      send_it      = 1'b0;
      pixel_index  = '0;
      color_index  = '0;
      color_level  = '0;
      req_done     = '0;
      timeout_fire = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_idx;
               state_d = OWN;
            end
         end

         OWN: begin
            load_color  = req_load_color[owner_q];
            pixel_index = pixel_arr[owner_q];
            color_index = color_arr[owner_q];
            color_level = level_arr[owner_q];
            // An accepted send wins over a same-cycle request drop and over
            // the watchdog; an unaccepted send is simply dropped.
            if (req_send_it[owner_q] && ready_to_send) begin
               send_it = 1'b1;
               state_d = SEND;
            end else if (!req[owner_q]) begin
               state_d = RELEASE;
            end else if (hold_expired) begin
               timeout_fire = 1'b1;
               state_d      = RELEASE;
            end
         end

         SEND: begin
            // The frame is already on the wire: request drops are ignored
            // until the driver finishes its latch interval.
            if (done_wait) begin
               req_done[owner_q] = 1'b1;
               state_d           = RELEASE;
            end
         end

         RELEASE: begin
            last_owner_d = owner_q;
            state_d      = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign frame_done = (state_q == SEND) && done_wait;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
      end
   end

   neo_counter #(
      .WIDTH (FRAME_CNT_W)
   ) u_frames (
      .clock (clock),
      .reset (reset),
      .clear (1'b0),
      .inc   (frame_done),
      .count (frames_sent)
   );

`ifdef NEO_ARB_TIMEOUT_EN
   logic [HOLD_CNT_W-1:0] hold_count;

   // Held at zero outside OWN, so the first OWN cycle reads 0 and the
   // TIMEOUT_CYCLES-th OWN cycle reads TIMEOUT_CYCLES-1.
   neo_counter #(
      .WIDTH (HOLD_CNT_W)
   ) u_hold (
      .clock (clock),
      .reset (reset),
      .clear (state_q != OWN),
      .inc   (state_q == OWN),
      .count (hold_count)
   );

   assign hold_expired = (state_q == OWN) &&
                         (hold_count == HOLD_CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err  = timeout_fire;
`else
   logic unused_timeout;

   assign hold_expired   = 1'b0;
   assign timeout_err    = 1'b0;
   assign unused_timeout = timeout_fire ^ (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_neo_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_neo_port_arbiter
// Directed steps for reset, routing, isolation, blocked send, abandon and
// reset-in-SEND (plus the watchdog when NEO_ARB_TIMEOUT_EN is defined),
// followed by randomized producer/driver traffic checked against a
// transaction-level round-robin model.
// -----------------------------------------------------------------------------
module tb_neo_port_arbiter;

   localparam int NR  = 2;
   localparam int TMO = 16;
   localparam int PW  = 3 * NR;
   localparam int CW  = 2 * NR;
   localparam int LW  = 8 * NR;
`ifdef NEO_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clock;
   logic          reset;
   logic [NR-1:0] req;
   logic [NR-1:0] req_load_color;
   logic [NR-1:0] req_send_it;
   logic [PW-1:0] req_pixel_index;
   logic [CW-1:0] req_color_index;
   logic [LW-1:0] req_color_level;
   logic [NR-1:0] gnt;
   logic [NR-1:0] req_ready_to_load;
   logic [NR-1:0] req_ready_to_send;
   logic [NR-1:0] req_done;
   logic          ready_to_load;
   logic          ready_to_send;
   logic          done_wait;
   logic          load_color;
   logic          send_it;
   logic [2:0]    pixel_index;
   logic [1:0]    color_index;
   logic [7:0]    color_level;
   logic [15:0]   frames_sent;
   logic          timeout_err;

   neo_port_arbiter #(
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .req               (req),
      .req_load_color    (req_load_color),
      .req_send_it       (req_send_it),
      .req_pixel_index   (req_pixel_index),
      .req_color_index   (req_color_index),
      .req_color_level   (req_color_level),
      .gnt               (gnt),
      .req_ready_to_load (req_ready_to_load),
      .req_ready_to_send (req_ready_to_send),
      .req_done          (req_done),
      .ready_to_load     (ready_to_load),
      .ready_to_send     (ready_to_send),
      .done_wait         (done_wait),
      .load_color        (load_color),
      .send_it           (send_it),
      .pixel_index       (pixel_index),
      .color_index       (color_index),
      .color_level       (color_level),
      .frames_sent       (frames_sent),
      .timeout_err       (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Model state for the randomized phase.
   int          cur_owner   = -1;
   int          model_last  = NR - 1;
   int          model_frames = 0;
   int          gap         = 1000;
   int          own_cnt     = 0;
   int          done_cnt    = 0;
   bit          sent        = 1'b0;
   bit          rel_pend    = 1'b0;
   logic [NR-1:0] prev_req  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // First requester strictly after 'last' in circular order, -1 if none.
   function automatic int rr_pick(input logic [NR-1:0] r, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (r[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   task automatic clear_inputs();
      req             = '0;
      req_load_color  = '0;
      req_send_it     = '0;
      req_pixel_index = '0;
      req_color_index = '0;
      req_color_level = '0;
      ready_to_load   = 1'b0;
      ready_to_send   = 1'b0;
      done_wait       = 1'b0;
   endtask

   // One clock of randomized producers + driver, checked against the model.
   task automatic rand_cycle(input bit all_req);
      logic [NR-1:0] g;
      int            exp_own;
      int            oh;
      bit            own_phase;
      bit            exp_send;
      bit            exp_tmo;
      logic [NR-1:0] exp_done;

      @(negedge clock);
      g = gnt;
      check("gnt_onehot0", 32'($onehot0(g)), 32'd1);
      check("frames_sent", 32'(frames_sent), 32'(model_frames & 32'hFFFF));
      if (cur_owner >= 0) begin
         check("gnt_release", 32'(g == '0), 32'(rel_pend));
         if (g == '0) begin
            model_last = cur_owner;
            cur_owner  = -1;
            gap        = 0;
            rel_pend   = 1'b0;
         end else begin
            check("gnt_hold", 32'(g), 32'(1 << cur_owner));
         end
      end else if (g != '0) begin
         exp_own = rr_pick(prev_req, model_last);
         check("gnt_pick", 32'(g), (exp_own < 0) ? 32'd0 : 32'(1 << exp_own));
         check("gnt_gap", 32'(gap >= 1), 32'd1);
         cur_owner = (exp_own >= 0) ? exp_own : 0;
         sent      = 1'b0;
         own_cnt   = 0;
         rel_pend  = 1'b0;
         done_cnt  = 0;
      end
      if (g == '0) gap++;

      // Producers raise requests; every requester also fires junk strobes.
      for (int i = 0; i < NR; i++) begin
         if (!req[i] && (i != cur_owner) && (all_req || ($urandom_range(2) == 0))) req[i] = 1'b1;
      end
      req_load_color  = NR'($urandom);
      req_send_it     = NR'($urandom);
      req_pixel_index = PW'($urandom);
      req_color_index = CW'($urandom);
      req_color_level = LW'($urandom);
      ready_to_load   = 1'($urandom);
      ready_to_send   = 1'($urandom);
      done_wait       = 1'b0;
      if ((cur_owner >= 0) && sent) begin
         if (done_cnt == 0) done_wait = 1'b1;
         else done_cnt--;
         if (!all_req && ($urandom_range(7) == 0)) req[cur_owner] = 1'b0;
      end else begin
         done_wait = ($urandom_range(3) == 0);
         if (cur_owner >= 0) begin
            if (!all_req && ($urandom_range(15) == 0)) begin
               req[cur_owner]         = 1'b0;
               req_send_it[cur_owner] = 1'b0;
            end else begin
               req_send_it[cur_owner] = ($urandom_range(3) == 0);
            end
         end
      end

      #1;
      own_phase = (cur_owner >= 0) && !sent;
      oh        = (cur_owner >= 0) ? (1 << cur_owner) : 0;
      exp_send  = own_phase && req_send_it[cur_owner] && ready_to_send;
      exp_tmo   = TMO_EN && own_phase && !exp_send && req[cur_owner] && (own_cnt == TMO - 1);
      exp_done  = ((cur_owner >= 0) && sent && done_wait) ? NR'(oh) : '0;

      check("load_color", 32'(load_color), own_phase ? 32'(req_load_color[cur_owner]) : 32'd0);
      check("pixel_index", 32'(pixel_index), own_phase ? 32'(req_pixel_index[cur_owner*3 +: 3]) : 32'd0);
      check("color_index", 32'(color_index), own_phase ? 32'(req_color_index[cur_owner*2 +: 2]) : 32'd0);
      check("color_level", 32'(color_level), own_phase ? 32'(req_color_level[cur_owner*8 +: 8]) : 32'd0);
      check("send_it", 32'(send_it), 32'(exp_send));
      check("rdy_load", 32'(req_ready_to_load), ready_to_load ? 32'(oh) : 32'd0);
      check("rdy_send", 32'(req_ready_to_send), ready_to_send ? 32'(oh) : 32'd0);
      check("req_done", 32'(req_done), 32'(exp_done));
      check("timeout_err", 32'(timeout_err), 32'(exp_tmo));

      if (own_phase) own_cnt++;
      if (exp_send) begin
         sent     = 1'b1;
         done_cnt = $urandom_range(3);
      end else if (own_phase && !req[cur_owner]) begin
         rel_pend = 1'b1;
      end else if (exp_tmo) begin
         rel_pend = 1'b1;
      end
      if (exp_done != '0) begin
         rel_pend = 1'b1;
         model_frames++;
         if (!all_req) req[cur_owner] = 1'($urandom);
      end
      prev_req = req;
   endtask

   initial begin
      bit got;

      clear_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      ready_to_load = 1'b1;
      ready_to_send = 1'b1;
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_frames", 32'(frames_sent), 32'd0);
      check("rst_load_color", 32'(load_color), 32'd0);
      check("rst_send_it", 32'(send_it), 32'd0);
      check("rst_data", 32'({pixel_index, color_index, color_level}), 32'd0);
      check("rst_rdy_load", 32'(req_ready_to_load), 32'd0);
      check("rst_req_done", 32'(req_done), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      ready_to_send = 1'b0;

      // Grant latency and owner data routing.
      req = 2'b01;
      @(negedge clock); #1;
      check("grant0_latency", 32'(gnt), 32'd1);
      req_load_color = 2'b01;
      req_pixel_index[0 +: 3] = 3'd3;
      req_color_index[0 +: 2] = 2'd1;
      req_color_level[0 +: 8] = 8'h10;
      #1;
      check("route_load", 32'(load_color), 32'd1);
      check("route_pixel", 32'(pixel_index), 32'd3);
      check("route_color", 32'(color_index), 32'd1);
      check("route_level", 32'(color_level), 32'h10);
      check("route_rdy_load", 32'(req_ready_to_load), 32'd1);

      // Non-owner strobes must not reach the driver.
      @(negedge clock);
      req_load_color = 2'b10;
      req_send_it    = 2'b10;
      req_pixel_index[3 +: 3] = 3'd7;
      ready_to_send  = 1'b1;
      #1;
      check("iso_load", 32'(load_color), 32'd0);
      check("iso_send", 32'(send_it), 32'd0);
      check("iso_pixel", 32'(pixel_index), 32'd3);
      check("iso_rdy_load", 32'(req_ready_to_load), 32'd1);
      check("iso_rdy_send", 32'(req_ready_to_send), 32'd1);

      // Send attempted while the driver is not ready.
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         req_load_color = 2'b00;
         req_send_it    = 2'b01;
         ready_to_send  = 1'b0;
         #1;
         check("blocked_send", 32'(send_it), 32'd0);
         check("blocked_gnt", 32'(gnt), 32'd1);
      end
      @(negedge clock);
      ready_to_send = 1'b1;
      #1;
      check("accepted_send", 32'(send_it), 32'd1);

      // In SEND: strobes ignored, data zero, request drop ignored.
      @(negedge clock);
      req_load_color = 2'b01;
      req            = 2'b00;
      #1;
      check("send_no_resend", 32'(send_it), 32'd0);
      check("send_no_load", 32'(load_color), 32'd0);
      check("send_data_zero", 32'(pixel_index), 32'd0);
      check("send_gnt", 32'(gnt), 32'd1);
      @(negedge clock);
      req_load_color = '0;
      req_send_it    = '0;
      done_wait      = 1'b1;
      #1;
      check("drop_ignored_gnt", 32'(gnt), 32'd1);
      check("done_pulse", 32'(req_done), 32'd1);
      check("frames_before", 32'(frames_sent), 32'd0);
      @(negedge clock);
      done_wait = 1'b0;
      #1;
      check("release_gnt", 32'(gnt), 32'd0);
      check("release_done", 32'(req_done), 32'd0);
      check("frames_after", 32'(frames_sent), 32'd1);

      // Abandon in OWN: no done, no count.
      @(negedge clock);
      req = 2'b01;
      @(negedge clock); #1;
      check("abandon_grant", 32'(gnt), 32'd1);
      req = 2'b00;
      #1;
      check("abandon_no_done", 32'(req_done), 32'd0);
      @(negedge clock); #1;
      check("abandon_release", 32'(gnt), 32'd0);
      check("abandon_frames", 32'(frames_sent), 32'd1);

      // Reset while in SEND.
      @(negedge clock);
      req = 2'b01;
      @(negedge clock); #1;
      check("rsend_grant", 32'(gnt), 32'd1);
      req_send_it   = 2'b01;
      ready_to_send = 1'b1;
      #1;
      check("rsend_send", 32'(send_it), 32'd1);
      @(negedge clock);
      req_send_it = '0;
      reset       = 1'b1;
      #1;
      check("rsend_in_send", 32'(gnt), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      req   = '0;
      #1;
      check("rsend_gnt", 32'(gnt), 32'd0);
      check("rsend_frames", 32'(frames_sent), 32'd0);
      check("rsend_send_it", 32'(send_it), 32'd0);
      check("rsend_load", 32'(load_color), 32'd0);

`ifdef NEO_ARB_TIMEOUT_EN
      // Watchdog: owner never sends; revoke on its 16th OWN cycle.
      clear_inputs();
      req = 2'b11;
      @(negedge clock); #1;
      check("tmo_grant", 32'(gnt), 32'd1);
      for (int n = 1; n <= TMO; n++) begin
         if (n > 1) begin
            @(negedge clock); #1;
         end
         check("tmo_pulse", 32'(timeout_err), 32'(n == TMO));
      end
      @(negedge clock); #1;
      check("tmo_release", 32'(gnt), 32'd0);
      check("tmo_no_done", 32'(req_done), 32'd0);
      got = 1'b0;
      for (int n = 0; n < 6 && !got; n++) begin
         @(negedge clock); #1;
         if (gnt != '0) got = 1'b1;
      end
      check("tmo_regrant_seen", 32'(got), 32'd1);
      check("tmo_regrant", 32'(gnt), 32'd2);
`endif

      // Clean start for the randomized phase.
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset        = 1'b0;
      cur_owner    = -1;
      model_last   = NR - 1;
      model_frames = 0;
      gap          = 1000;
      sent         = 1'b0;
      rel_pend     = 1'b0;
      prev_req     = '0;

      for (int c = 0; c < 200; c++) rand_cycle(1'b1);
      for (int c = 0; c < 800; c++) rand_cycle(1'b0);
      check("rand_frames_progress", 32'(model_frames > 5), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
